// File: rtl/float32_to_any_seq.sv
// float32_to_any_seq
//   Sequential IEEE-754 single precision to integer converter (u32, s32,
//   u64, s64) with a valid/ready handshake on both sides and one
//   conversion in flight at a time.
//
// Ports
//   clk            : clock, every state update happens on the rising edge
//   reset_n        : synchronous active-low reset
//   in_valid       : request valid
//   in_ready       : block is idle and can accept a request
//   in             : float32 operand
//   typeOp         : 0=u32, 1=s32, 2=u64, 3=s64
//   roundingMode   : 0=nearest-even, 1=toward zero, 2=toward -inf, 3=toward +inf
//   out_valid      : result valid, held until out_ready
//   out_ready      : consumer accepts the result
//   out            : 64-bit integer result (32-bit types are sign-extended from bit 31)
//   exceptionFlags : {NV, DZ, OF, UF, NX}; only NV and NX are ever set
module float32_to_any_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic [1:0]  typeOp,
  input  logic [1:0]  roundingMode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out,
  output logic [4:0]  exceptionFlags
);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] in_q;
  logic [1:0]  type_q;
  logic [1:0]  rm_q;
  logic [63:0] mag_q;
  logic        round_q;
  logic        sticky_q;
  logic        ovf_q;

  // Alignment of the captured operand into a 64-bit integer magnitude plus
  // round and sticky bits. The significand is placed in a Q64.64 fixed-point
  // word; e_eff-86 is (E-23)+64 with E the unbiased exponent, so the upper
  // half is the integer part and bit 63 is the first discarded bit.
  logic [7:0]   a_exp;
  logic [7:0]   a_exp_eff;
  logic [23:0]  a_sig;
  logic [127:0] a_fix;
  logic [63:0]  a_mag;
  logic         a_round;
  logic         a_sticky;
  logic         a_ovf;

  always_comb begin
    a_exp     = in_q[30:23];
    a_sig     = {a_exp != 8'd0, in_q[22:0]};
    a_exp_eff = (a_exp == 8'd0) ? 8'd1 : a_exp;
    a_fix     = {104'd0, a_sig} << (a_exp_eff - 8'd86);
    a_mag     = 64'd0;
    a_round   = 1'b0;
    a_sticky  = 1'b0;
    a_ovf     = 1'b0;
    if (a_exp_eff < 8'd126) begin
      // |value| < 0.5: nothing but sticky survives
      a_sticky = |a_sig;
    end else if (a_exp_eff >= 8'd191) begin
      // |value| >= 2^64 (also covers Inf and NaN)
      a_ovf = 1'b1;
    end else begin
      a_mag    = a_fix[127:64];
      a_round  = a_fix[63];
      a_sticky = |a_fix[62:0];
    end
  end

  // Rounding, range check against the requested type and result selection.
  // The rounded magnitude keeps a 65th bit so a carry out of 2^64-1 is seen
  // as out of range rather than wrapping to zero.
  logic        r_sign;
  logic        r_nan;
  logic        r_inf;
  logic        r_inc;
  logic [64:0] r_rounded;
  logic        r_in_range;
  logic [63:0] r_signed;
  logic [63:0] r_max;
  logic [63:0] r_min;
  logic [63:0] r_res;
  logic [63:0] r_out;
  logic        r_nv;
  logic        r_nx;

  always_comb begin
    r_sign = in_q[31];
    r_nan  = (&in_q[30:23]) && (|in_q[22:0]);
    r_inf  = (&in_q[30:23]) && !(|in_q[22:0]);
    case (rm_q)
      2'd0:    r_inc = round_q & (sticky_q | mag_q[0]);
      2'd1:    r_inc = 1'b0;
      2'd2:    r_inc = r_sign & (round_q | sticky_q);
      default: r_inc = ~r_sign & (round_q | sticky_q);
    endcase
    r_rounded = {1'b0, mag_q} + {64'd0, r_inc};

    // A negative value that rounds to zero is representable by every type
    if (!r_sign) begin
      case (type_q)
        2'd0:    r_in_range = r_rounded <= 65'h0_0000_0000_FFFF_FFFF;
        2'd1:    r_in_range = r_rounded <= 65'h0_0000_0000_7FFF_FFFF;
        2'd2:    r_in_range = !r_rounded[64];
        default: r_in_range = r_rounded <= 65'h0_7FFF_FFFF_FFFF_FFFF;
      endcase
    end else if (r_rounded == 65'd0) begin
      r_in_range = 1'b1;
    end else begin
      case (type_q)
        2'd1:    r_in_range = r_rounded <= 65'h0_0000_0000_8000_0000;
        2'd3:    r_in_range = r_rounded <= 65'h0_8000_0000_0000_0000;
        default: r_in_range = 1'b0;
      endcase
    end

    case (type_q)
      2'd0:    begin r_max = 64'h0000_0000_FFFF_FFFF; r_min = 64'd0; end
      2'd1:    begin r_max = 64'h0000_0000_7FFF_FFFF; r_min = 64'h0000_0000_8000_0000; end
      2'd2:    begin r_max = 64'hFFFF_FFFF_FFFF_FFFF; r_min = 64'd0; end
      default: begin r_max = 64'h7FFF_FFFF_FFFF_FFFF; r_min = 64'h8000_0000_0000_0000; end
    endcase

    r_signed = r_sign ? (~r_rounded[63:0] + 64'd1) : r_rounded[63:0];
    r_nv     = r_nan | r_inf | ovf_q | ~r_in_range;
    r_nx     = (round_q | sticky_q) & ~r_nv;

    if (r_nan)
      r_res = r_max;
    else if (r_nv)
      r_res = r_sign ? r_min : r_max;
    else
      r_res = r_signed;

    // 32-bit results, unsigned included, are sign-extended from bit 31
    r_out = type_q[1] ? r_res : {{32{r_res[31]}}, r_res[31:0]};
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out            <= 64'd0;
      exceptionFlags <= 5'd0;
      in_q           <= 32'd0;
      type_q         <= 2'd0;
      rm_q           <= 2'd0;
      mag_q          <= 64'd0;
      round_q        <= 1'b0;
      sticky_q       <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_q     <= in;
            type_q   <= typeOp;
            rm_q     <= roundingMode;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          mag_q    <= a_mag;
          round_q  <= a_round;
          sticky_q <= a_sticky;
          ovf_q    <= a_ovf;
          state    <= ROUND;
        end
        ROUND: begin
          out            <= r_out;
          exceptionFlags <= {r_nv, 3'b000, r_nx};
          out_valid      <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float32_to_any_seq.sv
// tb_float32_to_any_seq
//   Directed self-checking bench for float32_to_any_seq. Each scenario task
//   drives its own vectors and compares against hand-computed results.
module tb_float32_to_any_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'd0;
  logic [1:0]  type_op = 2'd0;
  logic [1:0]  rounding_mode = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_word;
  logic [4:0]  flags;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] op;
    logic [1:0]  t;
    logic [1:0]  rm;
    logic [63:0] exp_out;
    logic [4:0]  exp_flags;
    string       name;
  } vec_t;

  float32_to_any_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in             (in_word),
    .typeOp         (type_op),
    .roundingMode   (rounding_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out            (out_word),
    .exceptionFlags (flags)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] op, input logic [1:0] t, input logic [1:0] rm,
                              input logic [63:0] eo, input logic [4:0] ef, input string name);
    vec_t v;
    v.op = op; v.t = t; v.rm = rm; v.exp_out = eo; v.exp_flags = ef; v.name = name;
    return v;
  endfunction

  // Issue one request, wait (bounded) for the result, capture it, release it
  task automatic run_conv(input logic [31:0] op, input logic [1:0] t, input logic [1:0] rm,
                          output logic [63:0] o, output logic [4:0] f);
    int n;
    @(negedge clk);
    in_word = op; type_op = t; rounding_mode = rm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      vectors++; miscompares++;
      $display("[TB] FAIL result_timeout: got out_valid=%0b expected 1 within 8 cycles", out_valid);
    end
    o = out_word;
    f = flags;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++;
    if (out_word !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_out: got %h expected 0", out_word); end
    vectors++;
    if (flags !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_flags: got %h expected 00", flags); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rounding();
    vec_t v[5];
    logic [63:0] o;
    logic [4:0]  f;
    v[0] = mk(32'h3FC00000, 2'd1, 2'd0, 64'h0000000000000002, 5'h01, "1.5_s32_rne");
    v[1] = mk(32'h3FC00000, 2'd1, 2'd1, 64'h0000000000000001, 5'h01, "1.5_s32_rtz");
    v[2] = mk(32'hC0200000, 2'd3, 2'd0, 64'hFFFFFFFFFFFFFFFE, 5'h01, "m2.5_s64_rne");
    v[3] = mk(32'hC0200000, 2'd3, 2'd2, 64'hFFFFFFFFFFFFFFFD, 5'h01, "m2.5_s64_rdn");
    v[4] = mk(32'h40200000, 2'd3, 2'd3, 64'h0000000000000003, 5'h01, "2.5_s64_rup");
    for (int i = 0; i < 5; i++) begin
      run_conv(v[i].op, v[i].t, v[i].rm, o, f);
      vectors++;
      if (o !== v[i].exp_out) begin miscompares++; $display("[TB] FAIL %s_out: got %h expected %h", v[i].name, o, v[i].exp_out); end
      vectors++;
      if (f !== v[i].exp_flags) begin miscompares++; $display("[TB] FAIL %s_flags: got %h expected %h", v[i].name, f, v[i].exp_flags); end
    end
  endtask

  task automatic test_range();
    vec_t v[6];
    logic [63:0] o;
    logic [4:0]  f;
    v[0] = mk(32'h4F000000, 2'd1, 2'd0, 64'h000000007FFFFFFF, 5'h10, "2p31_s32");
    v[1] = mk(32'h4F000000, 2'd0, 2'd0, 64'hFFFFFFFF80000000, 5'h00, "2p31_u32");
    v[2] = mk(32'h5F800000, 2'd2, 2'd0, 64'hFFFFFFFFFFFFFFFF, 5'h10, "2p64_u64");
    v[3] = mk(32'hCF000000, 2'd1, 2'd0, 64'hFFFFFFFF80000000, 5'h00, "m2p31_s32");
    v[4] = mk(32'h5F000000, 2'd3, 2'd0, 64'h7FFFFFFFFFFFFFFF, 5'h10, "2p63_s64");
    v[5] = mk(32'h5F000000, 2'd2, 2'd0, 64'h8000000000000000, 5'h00, "2p63_u64");
    for (int i = 0; i < 6; i++) begin
      run_conv(v[i].op, v[i].t, v[i].rm, o, f);
      vectors++;
      if (o !== v[i].exp_out) begin miscompares++; $display("[TB] FAIL %s_out: got %h expected %h", v[i].name, o, v[i].exp_out); end
      vectors++;
      if (f !== v[i].exp_flags) begin miscompares++; $display("[TB] FAIL %s_flags: got %h expected %h", v[i].name, f, v[i].exp_flags); end
    end
  endtask

  task automatic test_special();
    vec_t v[10];
    logic [63:0] o;
    logic [4:0]  f;
    v[0] = mk(32'h7FC00000, 2'd2, 2'd0, 64'hFFFFFFFFFFFFFFFF, 5'h10, "nan_u64");
    v[1] = mk(32'h7FC00000, 2'd1, 2'd0, 64'h000000007FFFFFFF, 5'h10, "nan_s32");
    v[2] = mk(32'hBF000000, 2'd0, 2'd1, 64'h0000000000000000, 5'h01, "m0.5_u32_rtz");
    v[3] = mk(32'hBF000000, 2'd0, 2'd2, 64'h0000000000000000, 5'h10, "m0.5_u32_rdn");
    v[4] = mk(32'hFF800000, 2'd1, 2'd0, 64'hFFFFFFFF80000000, 5'h10, "minf_s32");
    v[5] = mk(32'h7F800000, 2'd0, 2'd0, 64'hFFFFFFFFFFFFFFFF, 5'h10, "pinf_u32");
    v[6] = mk(32'h80000000, 2'd3, 2'd0, 64'h0000000000000000, 5'h00, "negzero_s64");
    v[7] = mk(32'h00000001, 2'd1, 2'd3, 64'h0000000000000001, 5'h01, "subn_s32_rup");
    v[8] = mk(32'h80000001, 2'd1, 2'd2, 64'hFFFFFFFFFFFFFFFF, 5'h01, "msubn_s32_rdn");
    v[9] = mk(32'h00000001, 2'd1, 2'd0, 64'h0000000000000000, 5'h01, "subn_s32_rne");
    for (int i = 0; i < 10; i++) begin
      run_conv(v[i].op, v[i].t, v[i].rm, o, f);
      vectors++;
      if (o !== v[i].exp_out) begin miscompares++; $display("[TB] FAIL %s_out: got %h expected %h", v[i].name, o, v[i].exp_out); end
      vectors++;
      if (f !== v[i].exp_flags) begin miscompares++; $display("[TB] FAIL %s_flags: got %h expected %h", v[i].name, f, v[i].exp_flags); end
    end
  endtask

  // Result held under back-pressure, then a request issued the cycle after
  // the output handshake; its result appears on the third edge counting the
  // accepting edge as the first.
  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    in_word = 32'h3FC00000; type_op = 2'd1; rounding_mode = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin @(negedge clk); n++; end
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_first_valid: got %b expected 1", out_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_ctrl_c%0d: got valid=%b ready=%b expected valid=1 ready=0", c, out_valid, in_ready);
      end
      vectors++;
      if (out_word !== 64'h2 || flags !== 5'h01) begin
        miscompares++;
        $display("[TB] FAIL hold_data_c%0d: got %h/%h expected 0000000000000002/01", c, out_word, flags);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    in_word = 32'hC0200000; type_op = 2'd3; rounding_mode = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: got ready=%b valid=%b expected ready=0 valid=0", in_ready, out_valid);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 64'hFFFFFFFFFFFFFFFE || flags !== 5'h01) begin
      miscompares++;
      $display("[TB] FAIL b2b_result: got valid=%b %h/%h expected 1 FFFFFFFFFFFFFFFE/01", out_valid, out_word, flags);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Reset while the conversion sits in ROUND; out still holds the previous
  // nonzero result, so clearing it is observable.
  task automatic test_reset_mid();
    logic [63:0] o;
    logic [4:0]  f;
    @(negedge clk);
    in_word = 32'h4F000000; type_op = 2'd0; rounding_mode = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_ctrl: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    vectors++;
    if (out_word !== 64'd0 || flags !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_data: got %h/%h expected 0/00", out_word, flags);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ghost_c%0d: got valid=%b expected 0", c, out_valid); end
    end
    run_conv(32'h3FC00000, 2'd1, 2'd1, o, f);
    vectors++;
    if (o !== 64'h1 || f !== 5'h01) begin
      miscompares++;
      $display("[TB] FAIL midreset_recover: got %h/%h expected 0000000000000001/01", o, f);
    end
  endtask

  initial begin
    $display("[TB] starting float32_to_any_seq bench");
    test_reset();
    test_rounding();
    test_range();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
